sr_excitation_driver: RTL

//  Drives a clocked SR flip-flop (sampled on posedge CP) from a stream of target-value requests.
//  - Maps current->target to S/R excitation per the SR excitation table.
//  - Holds the excitation for a programmable number of clock edges.
//  - Optionally confirms the flip-flop's Q/Qn feedback before reporting completion.
//  - Never issues S=R=1. Sits between control logic and any SR storage element in the design.

---
 rtl/sr_drv_pkg.sv | 28 ++
 rtl/sr_exc_checker.sv | 22 ++
 rtl/sr_excitation_lut.sv | 16 +
 rtl/sr_excitation_driver.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/sr_drv_pkg.sv
// Shared types for the SR flip-flop excitation driver: FSM states, {S,R}
// excitation codes and the excitation-table lookup.
package sr_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Excitation codes are packed as {S,R}
    localparam logic [1:0] EXC_HOLD    = 2'b00;
    localparam logic [1:0] EXC_SET     = 2'b10;
    localparam logic [1:0] EXC_RST     = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL = 2'b11;

    function automatic logic [1:0] sr_excitation(input logic cur, input logic target);
        logic [1:0] exc;
        case ({cur, target})
            2'b01:   exc = EXC_SET;
            2'b10:   exc = EXC_RST;
            default: exc = EXC_HOLD;
        endcase
        return exc;
    endfunction

endpackage

// File: rtl/sr_exc_checker.sv
// Runtime invariants of the SR excitation driver: legal excitation codes,
// S/R only while driving, done/err only in the completion cycle.
module sr_exc_checker
    import sr_drv_pkg::*;
(
    input logic       clk,
    input logic       rst_n,
    input logic [1:0] lut_exc,
    input logic       s,
    input logic       r,
    input logic       done,
    input logic       err,
    input logic       in_drive,
    input logic       in_done
);

    lut_legal_a:  assert property (@(posedge clk) disable iff (!rst_n) lut_exc != EXC_ILLEGAL);
    sr_excl_a:    assert property (@(posedge clk) disable iff (!rst_n) !(s && r));
    sr_drive_a:   assert property (@(posedge clk) disable iff (!rst_n) (s || r) |-> in_drive);
    done_state_a: assert property (@(posedge clk) disable iff (!rst_n) (done || err) |-> in_done);

endmodule

// File: rtl/sr_excitation_lut.sv
// Combinational SR excitation table: current state and target to {S,R}.
// The illegal code 2'b11 is unreachable by construction of sr_excitation().
module sr_excitation_lut
    import sr_drv_pkg::*;
(
    input  logic       cur,
    input  logic       target,
    output logic [1:0] exc
);

    // Table lookup
    always_comb begin
        exc = sr_excitation(cur, target);
    end

endmodule

// File: rtl/sr_excitation_driver.sv
// Request-driven S/R excitation driver for a clocked SR flip-flop.
// Optional feedback confirmation is enabled by defining SR_FEEDBACK_CHECK_EN.
module sr_excitation_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_CYCLES = 1,
    parameter int TIMEOUT      = 4
) (
    input  logic CP,
    input  logic RDn,
    input  logic req_valid,
    input  logic req_d,
    output logic req_ready,
    output logic S,
    output logic R,
    input  logic Q_fb,
    input  logic Qn_fb,
    output logic done,
    output logic err,
    output logic q_track
);

    // One counter serves both the pulse length and the feedback timeout
    localparam int CNT_MAX = (PULSE_CYCLES > TIMEOUT) ? PULSE_CYCLES : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 1);
`ifdef SR_FEEDBACK_CHECK_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT - 1);
`endif

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              target_r;
    logic [1:0]        exc_s;
    logic              accept_s;

    assign accept_s = req_valid && req_ready;

`ifndef SR_FEEDBACK_CHECK_EN
    logic unused_fb_s;
    assign unused_fb_s = Q_fb ^ Qn_fb;
`endif

    sr_excitation_lut u_lut (
        .cur    (q_track),
        .target (req_d),
        .exc    (exc_s)
    );

    sr_exc_checker u_chk (
        .clk      (CP),
        .rst_n    (RDn),
        .lut_exc  (exc_s),
        .s        (S),
        .r        (R),
        .done     (done),
        .err      (err),
        .in_drive (state_r == DRIVE),
        .in_done  (state_r == DONE)
    );

    // Request FSM with registered excitation, handshake and status outputs
    always_ff @(posedge CP or negedge RDn) begin
        if (!RDn) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            target_r  <= 1'b0;
            req_ready <= 1'b1;
            S         <= 1'b0;
            R         <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            q_track   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        target_r  <= req_d;
                        req_ready <= 1'b0;
                        if (exc_s == EXC_HOLD) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                            q_track <= req_d;
                        end else begin
                            state_r <= DRIVE;
                            {S, R}  <= exc_s;
                            cnt_r   <= PULSE_LOAD;
                        end
                    end
                end
                DRIVE: begin
                    if (cnt_r == CNT_ZERO) begin
                        {S, R} <= EXC_HOLD;
`ifdef SR_FEEDBACK_CHECK_EN
                        state_r <= CHECK;
                        cnt_r   <= TIMEOUT_LOAD;
`else
                        state_r <= DONE;
                        done    <= 1'b1;
                        q_track <= target_r;
`endif
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
`ifdef SR_FEEDBACK_CHECK_EN
                CHECK: begin
                    if ((Q_fb == target_r) && (Qn_fb == !target_r)) begin
                        state_r <= DONE;
                        done    <= 1'b1;
                        q_track <= target_r;
                    end else if (cnt_r == CNT_ZERO) begin
                        // Give up and resynchronise to whatever Q reports
                        state_r <= DONE;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        q_track <= Q_fb;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
`endif
                DONE: begin
                    state_r   <= IDLE;
                    cnt_r     <= CNT_ZERO;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= CNT_ZERO;
                    S         <= 1'b0;
                    R         <= 1'b0;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
